// File: rtl/lfsr_gen_if.sv
// Stimulus/response bundle for lfsr_gen.
// Compile-time options: none.
//
// Ports, grouped by direction as seen from the LFSR core (slave):
//   en, load, seed_in, din                     -> into the core
//   dout, state, period, period_hit, zero_recov <- out of the core
interface lfsr_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             din;
    logic             dout;
    logic [WIDTH-1:0] state;
    logic [CNT_W-1:0] period;
    logic             period_hit;
    logic             zero_recov;

    modport master (
        output en,
        output load,
        output seed_in,
        output din,
        input  dout,
        input  state,
        input  period,
        input  period_hit,
        input  zero_recov
    );

    modport slave (
        input  en,
        input  load,
        input  seed_in,
        input  din,
        output dout,
        output state,
        output period,
        output period_hit,
        output zero_recov
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised LFSR / scrambler core: Fibonacci or Galois form,
// serial data injection, run-time seed load and period measurement.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - lfsr_gen_if.slave (en, load, seed_in, din in;
//            dout, state, period, period_hit, zero_recov out)
//
// Parameters: WIDTH (>=2), TAPS, SEED (nonzero), GALOIS, CNT_W.
//
// Compile-time option: LFSR_GEN_ZERO_RECOVER_EN
//   defined   - an all-zero next state is replaced by the reference
//               seed (or SEED if the reference is zero), zero_recov
//               pulses and the step counter restarts.
//   undefined - all-zero states are taken as computed; zero_recov
//               is tied low.
module lfsr_gen #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hD9,
    parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit               GALOIS = 1'b0,
    parameter int               CNT_W  = WIDTH
) (
    input logic       clk,
    input logic       reset,
    lfsr_gen_if.slave bus
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] next_state;
    logic [CNT_W-1:0] steps_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] steps_inc;
    logic             hit_q;
    logic             next_is_ref;

    // One LFSR step of the current state with din folded into
    // the feedback term.
    if (GALOIS) begin : g_galois
        logic fb;
        assign fb         = state_q[WIDTH-1] ^ bus.din;
        assign next_state = {state_q[WIDTH-2:0], 1'b0}
                          ^ ({WIDTH{fb}} & TAPS);
    end else begin : g_fibonacci
        logic fb;
        assign fb         = (^(state_q & TAPS)) ^ bus.din;
        assign next_state = {state_q[WIDTH-2:0], fb};
    end

    // The period is counted including the step that lands on the
    // reference, hence steps+1; both wrap modulo 2^CNT_W.
    assign steps_inc   = steps_q + CNT_W'(1);
    assign next_is_ref = (next_state == ref_q);

`ifdef LFSR_GEN_ZERO_RECOVER_EN
    logic             zr_q;
    logic             next_is_zero;
    logic [WIDTH-1:0] recover_state;

    // A zero reference would recover straight back into lock-up,
    // so fall back to the reset seed in that case.
    assign next_is_zero  = (next_state == '0);
    assign recover_state = (ref_q == '0) ? SEED : ref_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            ref_q    <= SEED;
            steps_q  <= '0;
            period_q <= '0;
            hit_q    <= 1'b0;
            zr_q     <= 1'b0;
        end else if (bus.load) begin
            state_q  <= bus.seed_in;
            ref_q    <= bus.seed_in;
            steps_q  <= '0;
            hit_q    <= 1'b0;
            zr_q     <= 1'b0;
        end else if (bus.en) begin
            if (next_is_zero) begin
                state_q <= recover_state;
                steps_q <= '0;
                hit_q   <= 1'b0;
                zr_q    <= 1'b1;
            end else if (next_is_ref) begin
                state_q  <= next_state;
                period_q <= steps_inc;
                steps_q  <= '0;
                hit_q    <= 1'b1;
                zr_q     <= 1'b0;
            end else begin
                state_q <= next_state;
                steps_q <= steps_inc;
                hit_q   <= 1'b0;
                zr_q    <= 1'b0;
            end
        end else begin
            hit_q <= 1'b0;
            zr_q  <= 1'b0;
        end
    end

    assign bus.zero_recov = zr_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            ref_q    <= SEED;
            steps_q  <= '0;
            period_q <= '0;
            hit_q    <= 1'b0;
        end else if (bus.load) begin
            state_q <= bus.seed_in;
            ref_q   <= bus.seed_in;
            steps_q <= '0;
            hit_q   <= 1'b0;
        end else if (bus.en) begin
            state_q <= next_state;
            if (next_is_ref) begin
                period_q <= steps_inc;
                steps_q  <= '0;
                hit_q    <= 1'b1;
            end else begin
                steps_q <= steps_inc;
                hit_q   <= 1'b0;
            end
        end else begin
            hit_q <= 1'b0;
        end
    end

    assign bus.zero_recov = 1'b0;
`endif

    assign bus.state      = state_q;
    assign bus.dout       = state_q[WIDTH-1];
    assign bus.period     = period_q;
    assign bus.period_hit = hit_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a vector table on the default
// Fibonacci core plus hand sequences for Galois, period and wrap.
module tb_lfsr_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    lfsr_gen_if #(.WIDTH(8), .CNT_W(8)) if_fib ();
    lfsr_gen_if #(.WIDTH(8), .CNT_W(8)) if_gal ();
    lfsr_gen_if #(.WIDTH(4), .CNT_W(4)) if_w4 ();
    lfsr_gen_if #(.WIDTH(4), .CNT_W(3)) if_w4c3 ();

    lfsr_gen #(
        .WIDTH(8), .TAPS(8'hD9), .SEED(8'h01),
        .GALOIS(1'b0), .CNT_W(8)
    ) u_fib (.clk(clk), .reset(reset), .bus(if_fib));

    lfsr_gen #(
        .WIDTH(8), .TAPS(8'hD9), .SEED(8'h01),
        .GALOIS(1'b1), .CNT_W(8)
    ) u_gal (.clk(clk), .reset(reset), .bus(if_gal));

    lfsr_gen #(
        .WIDTH(4), .TAPS(4'b1001), .SEED(4'h1),
        .GALOIS(1'b0), .CNT_W(4)
    ) u_w4 (.clk(clk), .reset(reset), .bus(if_w4));

    lfsr_gen #(
        .WIDTH(4), .TAPS(4'b1001), .SEED(4'h1),
        .GALOIS(1'b0), .CNT_W(3)
    ) u_w4c3 (.clk(clk), .reset(reset), .bus(if_w4c3));

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic       din;
        logic [7:0] seed;
        logic [7:0] st;
        logic       dout;
        logic [7:0] per;
        logic       hit;
        logic       zr;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    function automatic vec_t v(int rst, int ld, int en, int din,
                               int seed, int st, int dout,
                               int per, int hit, int zr);
        vec_t r;
        r.rst  = rst[0];
        r.ld   = ld[0];
        r.en   = en[0];
        r.din  = din[0];
        r.seed = seed[7:0];
        r.st   = st[7:0];
        r.dout = dout[0];
        r.per  = per[7:0];
        r.hit  = hit[0];
        r.zr   = zr[0];
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq4 [15];

    initial begin
        if_fib.en = 0;  if_fib.load = 0;  if_fib.din = 0;  if_fib.seed_in = 0;
        if_gal.en = 0;  if_gal.load = 0;  if_gal.din = 0;  if_gal.seed_in = 0;
        if_w4.en = 0;   if_w4.load = 0;   if_w4.din = 0;   if_w4.seed_in = 0;
        if_w4c3.en = 0; if_w4c3.load = 0; if_w4c3.din = 0; if_w4c3.seed_in = 0;

        seq4 = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};

        //            rst ld en din seed  state dout per hit zr
        vt[0]  = v(1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0);
        vt[1]  = v(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, 0, 0);
        vt[2]  = v(0, 0, 1, 0, 8'h00, 8'h07, 0, 0, 0, 0);
        vt[3]  = v(0, 0, 1, 0, 8'h00, 8'h0F, 0, 0, 0, 0);
        vt[4]  = v(0, 0, 1, 0, 8'h00, 8'h1E, 0, 0, 0, 0);
        vt[5]  = v(0, 1, 1, 1, 8'hA5, 8'hA5, 1, 0, 0, 0);
        vt[6]  = v(0, 0, 1, 0, 8'h00, 8'h4A, 0, 0, 0, 0);
        vt[7]  = v(0, 0, 1, 1, 8'h00, 8'h95, 1, 0, 0, 0);
        vt[8]  = v(0, 0, 0, 1, 8'h00, 8'h95, 1, 0, 0, 0);
        vt[9]  = v(1, 1, 1, 0, 8'h33, 8'h01, 0, 0, 0, 0);
        vt[10] = v(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
`ifdef LFSR_GEN_ZERO_RECOVER_EN
        vt[11] = v(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0, 1);
        vt[12] = v(0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0);
`else
        vt[11] = v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 1, 0);
        vt[12] = v(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
`endif
        vt[13] = v(1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            reset          = vt[i].rst;
            if_fib.load    = vt[i].ld;
            if_fib.en      = vt[i].en;
            if_fib.din     = vt[i].din;
            if_fib.seed_in = vt[i].seed;
            tick();
            chk($sformatf("v%0d state", i), 32'(if_fib.state), 32'(vt[i].st));
            chk($sformatf("v%0d dout", i), 32'(if_fib.dout), 32'(vt[i].dout));
            chk($sformatf("v%0d period", i), 32'(if_fib.period), 32'(vt[i].per));
            chk($sformatf("v%0d hit", i), 32'(if_fib.period_hit), 32'(vt[i].hit));
            chk($sformatf("v%0d zr", i), 32'(if_fib.zero_recov), 32'(vt[i].zr));
        end
        if_fib.en = 0;
        if_fib.load = 0;
        if_fib.din = 0;

        // Galois form
        reset = 1;
        tick();
        reset = 0;
        chk("gal reset", 32'(if_gal.state), 32'h01);
        if_gal.load = 1;
        if_gal.seed_in = 8'h80;
        tick();
        if_gal.load = 0;
        if_gal.en = 1;
        tick();
        chk("gal 80->D9", 32'(if_gal.state), 32'hD9);
        if_gal.en = 0;
        if_gal.load = 1;
        if_gal.seed_in = 8'h01;
        tick();
        if_gal.load = 0;
        if_gal.en = 1;
        tick();
        chk("gal 01->02", 32'(if_gal.state), 32'h02);
        if_gal.din = 1;
        tick();
        chk("gal din 02->DD", 32'(if_gal.state), 32'hDD);
        if_gal.en = 0;
        if_gal.din = 0;

        // 4-bit max-length sequence, two full periods
        reset = 1;
        tick();
        reset = 0;
        chk("w4 reset", 32'(if_w4.state), 32'h1);
        chk("w4 reset period", 32'(if_w4.period), 32'h0);
        if_w4.en = 1;
        if_w4c3.en = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk($sformatf("w4 s%0d", k), 32'(if_w4.state), 32'(seq4[k % 15]));
            chk($sformatf("w4 hit%0d", k), 32'(if_w4.period_hit),
                32'((k == 14) || (k == 29)));
            chk($sformatf("w4c3 hit%0d", k), 32'(if_w4c3.period_hit),
                32'((k == 14) || (k == 29)));
            if (k == 13) begin
                chk("w4 period pre", 32'(if_w4.period), 32'h0);
                chk("w4c3 period pre", 32'(if_w4c3.period), 32'h0);
            end
            if ((k == 14) || (k == 29)) begin
                chk($sformatf("w4 period%0d", k), 32'(if_w4.period), 32'd15);
                chk($sformatf("w4c3 period%0d", k), 32'(if_w4c3.period), 32'd7);
            end
        end
        if_w4c3.en = 0;

        // load beats en/din and keeps the measured period
        if_w4.load = 1;
        if_w4.din = 1;
        if_w4.seed_in = 4'h5;
        tick();
        chk("w4 load state", 32'(if_w4.state), 32'h5);
        chk("w4 load period", 32'(if_w4.period), 32'd15);
        chk("w4 load hit", 32'(if_w4.period_hit), 32'h0);
        if_w4.load = 0;
        if_w4.din = 0;
        tick();
        chk("w4 after load", 32'(if_w4.state), 32'hB);
        if_w4.en = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("w4 reset clears period", 32'(if_w4.period), 32'h0);
        chk("w4c3 reset clears period", 32'(if_w4c3.period), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
